// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start detection, edge/bit counting, frame deserialisation
// and start/parity/stop checking with one-cycle result pulses.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  sampled_bit,
  output logic                  dat_samp_en,
  output logic [5:0]            edge_cnt,
  output logic [3:0]            bit_cnt,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                r_state;
  logic [5:0]            r_ps;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic                  r_par_mis;
  logic [DATA_WIDTH-1:0] r_shift;

  logic                  w_ps_legal;
  logic                  w_last_edge;
  logic                  w_stop_bad;
  logic                  w_par_bad;
  logic [DATA_WIDTH-1:0] w_shift_nxt;

  always_comb begin
    w_ps_legal  = (prescale == 6'd8) || (prescale == 6'd16) || (prescale == 6'd32);
    w_last_edge = (edge_cnt == (r_ps - 6'd1));
    w_stop_bad  = ~sampled_bit;
    w_par_bad   = r_par_en & r_par_mis;
    // LSB-first: each new bit enters at the top and works its way down.
    w_shift_nxt = r_shift >> 1;
    w_shift_nxt[DATA_WIDTH-1] = sampled_bit;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= IDLE;
      r_ps        <= '0;
      r_par_en    <= 1'b0;
      r_par_typ   <= 1'b0;
      r_par_mis   <= 1'b0;
      r_shift     <= '0;
      dat_samp_en <= 1'b0;
      edge_cnt    <= '0;
      bit_cnt     <= '0;
      P_DATA      <= '0;
      data_valid  <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;

      if (r_state == IDLE) begin
        dat_samp_en <= 1'b0;
        edge_cnt    <= '0;
        bit_cnt     <= '0;
        if (!RX_IN && w_ps_legal) begin
          r_state     <= START;
          r_ps        <= prescale;
          r_par_en    <= PAR_EN;
          r_par_typ   <= PAR_TYP;
          r_par_mis   <= 1'b0;
          dat_samp_en <= 1'b1;
        end
      end else begin
        if (w_last_edge) begin
          edge_cnt <= '0;
          bit_cnt  <= bit_cnt + 4'd1;
        end else begin
          edge_cnt <= edge_cnt + 6'd1;
        end

        if (w_last_edge) begin
          case (r_state)
            START: begin
              if (sampled_bit) begin
                r_state     <= IDLE;
                dat_samp_en <= 1'b0;
                edge_cnt    <= '0;
                bit_cnt     <= '0;
              end else begin
                r_state <= DATA;
              end
            end
            DATA: begin
              r_shift <= w_shift_nxt;
              if (bit_cnt == 4'(DATA_WIDTH)) begin
                r_state <= r_par_en ? PARITY : STOP;
              end
            end
            PARITY: begin
              r_par_mis <= sampled_bit ^ (^r_shift) ^ r_par_typ;
              r_state   <= STOP;
            end
            STOP: begin
              r_state     <= IDLE;
              dat_samp_en <= 1'b0;
              edge_cnt    <= '0;
              bit_cnt     <= '0;
              stp_err     <= w_stop_bad;
              par_err     <= w_par_bad;
              if (!w_stop_bad && !w_par_bad) begin
                data_valid <= 1'b1;
                P_DATA     <= r_shift;
              end
            end
            default: r_state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: frames are pushed to a scoreboard when sent and
// matched against result pulses (flags, word, arrival cycle) by a monitor.
module tb_uart_rx_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic [5:0] prescale = 6'd16;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       sampled_bit = 1'b1;
  logic       dat_samp_en;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  uart_rx_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .prescale(prescale),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .sampled_bit(sampled_bit),
    .dat_samp_en(dat_samp_en), .edge_cnt(edge_cnt), .bit_cnt(bit_cnt),
    .P_DATA(P_DATA), .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic        dv;
    logic        pe;
    logic        se;
    logic [7:0]  data;
    int unsigned at;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  last_good = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (data_valid || par_err || stp_err) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_pulse observed dv=%0b pe=%0b se=%0b expected none", data_valid, par_err, stp_err);
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("data_valid", 32'(data_valid), 32'(mon_e.dv));
        chk("par_err",    32'(par_err),    32'(mon_e.pe));
        chk("stp_err",    32'(stp_err),    32'(mon_e.se));
        chk("P_DATA",     32'(P_DATA),     32'(mon_e.data));
        chk("pulse_cycle", cyc, mon_e.at);
      end
    end
  end

  // One bit on the line; the sampler output trails RX_IN by a cycle.
  task automatic send_bit(input logic b, input int unsigned p);
    RX_IN = b;
    @(negedge CLK);
    sampled_bit = b;
    repeat (p - 1) @(negedge CLK);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic pbit, input logic stop,
                            input logic [5:0] mid_ps);
    int unsigned p;
    logic pen, typ;
    exp_t e;
    p   = int'(prescale);
    pen = PAR_EN;
    typ = PAR_TYP;
    e.pe = pen && (pbit != ((^data) ^ typ));
    e.se = !stop;
    e.dv = !e.pe && !e.se;
    if (e.dv) last_good = data;
    e.data = last_good;
    e.at = cyc + 1 + (2 + 8 + (pen ? 1 : 0)) * p;
    sb.push_back(e);
    send_bit(1'b0, p);
    prescale = mid_ps;
    for (int i = 0; i < 8; i++) send_bit(data[i], p);
    if (pen) send_bit(pbit, p);
    send_bit(stop, p);
    RX_IN = 1'b1;
    @(negedge CLK);
    sampled_bit = 1'b1;
    prescale = 6'(p);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 600) begin
      @(negedge CLK);
      n++;
    end
    chk(tag, 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_until(input int unsigned target);
    while (cyc < target) @(negedge CLK);
  endtask

  int unsigned t0;

  initial begin
    #1;
    chk("rst_dsen", 32'(dat_samp_en), 32'd0);
    chk("rst_edge", 32'(edge_cnt), 32'd0);
    chk("rst_bit",  32'(bit_cnt), 32'd0);
    chk("rst_pdata", 32'(P_DATA), 32'd0);
    chk("rst_pulses", 32'({data_valid, par_err, stp_err}), 32'd0);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    repeat (3) @(negedge CLK);

    // Parity frames at x16
    prescale = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    send_frame(8'hA5, 1'b0, 1'b1, 6'd16);
    drain("drain_good_par");
    send_frame(8'hA5, 1'b1, 1'b1, 6'd16);
    drain("drain_par_err");
    PAR_TYP = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b1, 6'd16);
    drain("drain_odd_par");

    // Stop error then good frame at x8, no parity
    prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b0, 6'd8);
    drain("drain_stp_err");
    send_frame(8'h3C, 1'b0, 1'b1, 6'd8);
    drain("drain_stp_ok");

    // Start glitch at x32
    prescale = 6'd32;
    t0 = cyc + 1;
    RX_IN = 1'b0; sampled_bit = 1'b0;
    repeat (4) @(negedge CLK);
    RX_IN = 1'b1;
    @(negedge CLK);
    sampled_bit = 1'b1;
    wait_until(t0 + 31);
    chk("glitch_dsen_hi", 32'(dat_samp_en), 32'd1);
    chk("glitch_edge31", 32'(edge_cnt), 32'd31);
    @(negedge CLK);
    chk("glitch_dsen_lo", 32'(dat_samp_en), 32'd0);
    chk("glitch_bit", 32'(bit_cnt), 32'd0);
    repeat (40) @(negedge CLK);
    chk("glitch_dsen_later", 32'(dat_samp_en), 32'd0);
    chk("glitch_no_pulse", 32'(sb.size()), 32'd0);

    // Back-to-back frames, 1-cycle gap
    prescale = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    send_frame(8'h01, 1'b1, 1'b1, 6'd16);
    send_frame(8'hFE, 1'b1, 1'b1, 6'd16);
    drain("drain_b2b");

    // Reset in mid-DATA
    PAR_EN = 1'b0;
    send_bit(1'b0, 16);
    send_bit(1'b1, 16);
    send_bit(1'b0, 16);
    send_bit(1'b1, 16);
    chk("mid_bit_cnt", 32'(bit_cnt), 32'd3);
    chk("mid_edge_cnt", 32'(edge_cnt), 32'd15);
    RST = 1'b0;
    #1;
    chk("abort_dsen", 32'(dat_samp_en), 32'd0);
    chk("abort_cnts", 32'({edge_cnt, bit_cnt}), 32'd0);
    chk("abort_pdata", 32'(P_DATA), 32'd0);
    chk("abort_pulses", 32'({data_valid, par_err, stp_err}), 32'd0);
    last_good = 8'h00;
    RX_IN = 1'b1; sampled_bit = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    send_frame(8'h5A, 1'b0, 1'b1, 6'd16);
    drain("drain_after_rst");

    // Mid-frame prescale change is ignored
    send_frame(8'hC3, 1'b0, 1'b1, 6'd8);
    drain("drain_ps_change");

    // Illegal prescale stays idle
    prescale = 6'd12;
    RX_IN = 1'b0; sampled_bit = 1'b0;
    repeat (40) @(negedge CLK);
    chk("ps12_dsen", 32'(dat_samp_en), 32'd0);
    chk("ps12_cnts", 32'({edge_cnt, bit_cnt}), 32'd0);
    RX_IN = 1'b1; sampled_bit = 1'b1;
    @(negedge CLK);
    prescale = 6'd16;
    repeat (20) @(negedge CLK);
    chk("final_idle_dsen", 32'(dat_samp_en), 32'd0);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
